// File: rtl/load_unit.sv
// Load path between execute and the data memory port: one or two aligned word reads per load,
// merged and then zero- or sign-extended.
module load_unit (
    input  logic        clk,
    input  logic        reset_n,
    output logic        read_ready,
    input  logic        read_req,
    input  logic [31:0] read_addr,
    input  logic [1:0]  read_width,
    input  logic        read_signed,
    output logic [31:0] read_data,
    output logic        read_data_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_byte_enable,
    output logic        mem_read_req,
    input  logic [31:0] mem_read_data,
    input  logic        mem_read_data_valid
);

    typedef enum logic [1:0] {StIdle, StIssueLow, StIssueHigh, StWaitData} state_e;

    state_e      state_q;
    logic [31:0] mem_addr_q;
    logic [3:0]  mem_be_q;
    logic        mem_req_q;
    logic [3:0]  be_hi_q;
    logic [1:0]  off_q;
    logic [1:0]  width_q;
    logic        signed_q;
    logic        rsp_cnt_q;
    logic [31:0] low_q;
    logic [31:0] read_data_q;
    logic        valid_q;

    logic [3:0]  size_mask;
    logic [7:0]  be8;
    logic [31:0] word_lo;
    logic [31:0] r;
    logic [31:0] merged;
    logic        spans;
    logic        last_rsp;

    always_comb begin
        case (read_width)
            2'b00:   size_mask = 4'h1;
            2'b01:   size_mask = 4'h3;
            default: size_mask = 4'hF;
        endcase
        be8 = {4'h0, size_mask} << read_addr[1:0];
    end

    // Second response pairs the stored low word with the incoming high word.
    always_comb begin
        word_lo = rsp_cnt_q ? low_q : mem_read_data;
        case (off_q)
            2'd0:    r = word_lo;
            2'd1:    r = {mem_read_data[7:0],  word_lo[31:8]};
            2'd2:    r = {mem_read_data[15:0], word_lo[31:16]};
            default: r = {mem_read_data[23:0], word_lo[31:24]};
        endcase
        case (width_q)
            2'b00:   merged = {{24{signed_q & r[7]}}, r[7:0]};
            2'b01:   merged = {{16{signed_q & r[15]}}, r[15:0]};
            default: merged = r;
        endcase
    end

    assign spans    = |be_hi_q;
    assign last_rsp = rsp_cnt_q || !spans;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            mem_addr_q  <= 32'h0;
            mem_be_q    <= 4'h0;
            mem_req_q   <= 1'b0;
            be_hi_q     <= 4'h0;
            off_q       <= 2'b00;
            width_q     <= 2'b00;
            signed_q    <= 1'b0;
            rsp_cnt_q   <= 1'b0;
            low_q       <= 32'h0;
            read_data_q <= 32'h0;
            valid_q     <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (read_req) begin
                        mem_addr_q <= {read_addr[31:2], 2'b00};
                        mem_be_q   <= be8[3:0];
                        mem_req_q  <= 1'b1;
                        be_hi_q    <= be8[7:4];
                        off_q      <= read_addr[1:0];
                        width_q    <= read_width;
                        signed_q   <= read_signed;
                        rsp_cnt_q  <= 1'b0;
                        state_q    <= StIssueLow;
                    end
                end
                StIssueLow: begin
                    if (mem_ready) begin
                        if (spans) begin
                            mem_addr_q <= {mem_addr_q[31:2] + 30'h1, 2'b00};
                            mem_be_q   <= be_hi_q;
                            state_q    <= StIssueHigh;
                        end else begin
                            mem_req_q <= 1'b0;
                            state_q   <= StWaitData;
                        end
                    end
                end
                StIssueHigh: begin
                    if (mem_ready) begin
                        mem_req_q <= 1'b0;
                        state_q   <= StWaitData;
                    end
                end
                default: ;
            endcase

            // Responses are captured in every busy state; stale ones in idle are dropped.
            if (state_q != StIdle && mem_read_data_valid) begin
                if (last_rsp) begin
                    read_data_q <= merged;
                    valid_q     <= 1'b1;
                    mem_req_q   <= 1'b0;
                    rsp_cnt_q   <= 1'b0;
                    state_q     <= StIdle;
                end else begin
                    low_q     <= mem_read_data;
                    rsp_cnt_q <= 1'b1;
                end
            end
        end
    end

    assign read_ready      = (state_q == StIdle);
    assign read_data       = read_data_q;
    assign read_data_valid = valid_q;
    assign mem_addr        = mem_addr_q;
    assign mem_byte_enable = mem_be_q;
    assign mem_read_req    = mem_req_q;

endmodule

// File: doc/load_unit.md
# load_unit

CPU-side load path between the execute stage and the data memory port. Accepts one byte, halfword or word load per request at any byte address. Issues one aligned word read, or two when the access crosses a word boundary. Merges the returned words, then zero- or sign-extends the result. It is the read-direction counterpart of the store path and uses the same request/ready memory handshake.

## Interface
- No parameters.
- clk  in  1  system clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- read_ready  out  1  combinational; high iff state is IDLE.
- read_req  in  1  load request; accepted on a rising edge where read_req && read_ready.
- read_addr  in  32  byte address of the load.
- read_width  in  2  00 byte, 01 halfword, 10 word, 11 treated as word.
- read_signed  in  1  1 = sign-extend the result, 0 = zero-extend; ignored for word.
- read_data  out  32  extended load result; valid only while read_data_valid is high.
- read_data_valid  out  1  registered one-cycle pulse.
- mem_ready  in  1  memory accepts the presented request this cycle.
- mem_addr  out  32  word-aligned read address (bits [1:0] always 0).
- mem_byte_enable  out  4  bytes of mem_addr that are used (informational for memory).
- mem_read_req  out  1  registered; held high until accepted.
- mem_read_data  in  32  returned word.
- mem_read_data_valid  in  1  returned word is valid this cycle; responses come back in issue order.

## Operation
- Size mask: m = 1, 3 or F for byte, half or word. Compute be8 = {4'h0, m} << read_addr[1:0] (8 bits). Low enables = be8[3:0], high enables = be8[7:4]. The access spans two words iff be8[7:4] != 0. Latch be8, read_addr[1:0], read_width and read_signed at acceptance.
- States:
  - IDLE: on read_req, register mem_addr = {read_addr[31:2], 2'b00}, mem_byte_enable = be8[3:0], mem_read_req = 1, then go to ISSUE_LOW.
  - ISSUE_LOW: hold the request until mem_ready. On mem_ready:
    - If the access spans: mem_addr = {mem_addr[31:2]+30'h1, 2'b00} (wraps 0xFFFFFFFC -> 0x00000000), mem_byte_enable = be8[7:4], request stays high, go to ISSUE_HIGH.
    - Otherwise: mem_read_req = 0, go to WAIT_DATA.
  - ISSUE_HIGH: on mem_ready, mem_read_req = 0, go to WAIT_DATA.
  - WAIT_DATA: wait for the remaining responses.
- Response capture: in any non-IDLE state, mem_read_data_valid stores the word. The first response goes to the low word, the second to the high word. A 1-bit response counter tracks this. Responses can arrive while in ISSUE_HIGH and must be captured there.
- Completion: the cycle the final expected response (1 or 2) is captured, register read_data and read_data_valid = 1 and go to IDLE. This applies from any non-IDLE state. Next cycle, read_data_valid = 0 unless a new completion occurs.
- Merge: r = ({high, low} >> {addr[1:0], 3'b000})[31:0].
  - byte: r[7:0] extended by r[7] if signed, else zeros.
  - half: r[15:0] extended by r[15] if signed, else zeros.
  - word: r.
- mem_read_data_valid in IDLE is ignored; this covers stale responses after reset.

## Timing
- Reset (async assert): state IDLE; read_ready = 1; read_data_valid = 0; read_data = 0; mem_read_req = 0; mem_addr = 0; mem_byte_enable = 0; internal registers 0. Any in-flight operation is abandoned.
- mem_read_req rises on the edge after acceptance. Memory returns each response no earlier than the cycle after the mem_ready cycle of that request.
- Latency with mem_ready high throughout and 1-cycle memory response: aligned load takes 3 cycles from the acceptance edge to read_data_valid; spanning load takes 4.
- read_ready returns high in the same cycle read_data_valid pulses. A new request may be accepted that cycle, giving back-to-back loads.
- mem_addr and mem_byte_enable are stable for as long as mem_read_req is high and mem_ready is low.

## Test plan
- Aligned word at 0x100, memory word 0xDEADBEEF: one request, mem_addr 0x100, be F -> read_data 0xDEADBEEF, single pulse.
- Byte at 0x103, memory word 0x80123456: signed -> 0xFFFFFF80; unsigned -> 0x00000080; be 8; one request each.
- Word at 0x102, words 0x11223344 @0x100 and 0x55667788 @0x104: requests 0x100/be C then 0x104/be 3 -> read_data 0x77881122.
- Signed half at 0x103 with the same memory: be 8 then be 1 -> 0xFFFF8811. Hold mem_ready low 3 cycles in each issue state: mem_addr and mem_byte_enable stay stable, no extra requests.
- First response arrives while in ISSUE_HIGH and the second two cycles after the second accept -> correct merge, exactly one read_data_valid pulse. Word at 0xFFFFFFFE: second address 0x00000000.
- Assert reset_n low during WAIT_DATA of a spanning load, release, then return a stale response -> outputs at reset values, stale word ignored, next aligned load returns correct data.
